id_ex_decode_reg: RTL and testbench
===================================

Name: id_ex_decode_reg

Overview:
- ID-stage decoder plus ID/EX pipeline register for the pipelined CPU.
- Decodes the ID instruction into the ALU_op encoding and the operand, write-back and memory controls the EX-stage ALU consumes.
- Registers these fields into EX, with hold (freeze), stall (bubble) and flush (bubble) control.
- Produces the 4-bit ALU_op the ALU decodes: 0000 add, 0001 sub, 0010 or, 0100 checked add (overflow returns A2).

Parameters:
- PC_W, 32, width of the PC carried with the instruction.
- NOP_OP, 4'b0000, ALU_op placed in a bubble.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_instr  input  32  instruction in ID.
- id_pc  input  PC_W  PC of id_instr.
- id_valid  input  1  id_instr is a real instruction.
- hold  input  1  freeze the EX register, e.g. a downstream busy.
- stall  input  1  ID does not advance this cycle (load-use); EX gets a bubble.
- flush  input  1  discard the ID instruction (branch redirect); EX gets a bubble.
- ex_alu_op  output  4  ALU_op for EX.
- ex_alu_src_imm  output  1  ALU A2 = ex_ext_imm, else rt value.
- ex_a1_zero  output  1  ALU A1 forced to 0 (lui).
- ex_ext_imm  output  32  extended immediate.
- ex_rs, ex_rt  output  5 each  source register numbers, used for forwarding.
- ex_wr_reg  output  5  destination register; 0 means no write.
- ex_reg_write  output  1  writes a GPR.
- ex_mem_read  output  1  lw.
- ex_mem_write  output  1  sw.
- ex_branch  output  1  beq.
- ex_illegal  output  1  unrecognised instruction.
- ex_valid  output  1  EX holds a real instruction.
- ex_pc  output  PC_W  PC of the EX instruction.

Behaviour:
- Decode (combinational, op = instr[31:26], funct = instr[5:0]):
  - addu (op 0, funct 100001): alu 0000, write rd.
  - subu (op 0, funct 100011): alu 0001, write rd.
  - cadd (op 0, funct 111111): alu 0100, write rd.
  - sll with instr == 0 (nop): alu 0000, no write, not illegal.
  - ori (001101): alu 0010, zero-extended imm, write rt.
  - lui (001111): alu 0010, imm = {instr[15:0], 16'h0}, a1_zero=1, write rt.
  - lw (100011): alu 0000, sign-extended imm, mem_read, write rt.
  - sw (101011): alu 0000, sign-extended imm, mem_write, no write.
  - beq (000100): alu 0001, rt as A2, branch, no write.
  - Anything else: illegal=1, all write and mem enables 0, alu NOP_OP.
- Register update, priority reset > hold > (flush | stall | !id_valid) > load:
  - reset (async) or bubble: ex_valid=0, every control output 0, ex_alu_op=NOP_OP, ex_wr_reg=0, ex_ext_imm=0, ex_rs=ex_rt=0, ex_pc=0, ex_illegal=0.
  - hold=1: all outputs keep their value, even when flush or stall is also 1. The requester re-asserts flush after hold drops.
  - Load: decoded fields are registered and ex_valid=1.
- Latency: exactly 1 cycle from id_instr to the ex_* outputs.
- ex_reg_write=1 requires ex_wr_reg != 0. A write to $0 is decoded with reg_write=0 and wr_reg=0.
- Reset deasserted mid-stream: the first edge loads normally. No state besides the register exists.
- Illegal instructions advance with ex_valid=1 and ex_illegal=1, and have no side-effect enables.

Test Plan:
- Reset asserted asynchronously mid-cycle -> all ex_* outputs 0 immediately, ex_alu_op=0000, ex_valid=0.
- id_instr=0x00221821 (addu $3,$1,$2), id_valid=1 -> next edge ex_alu_op=0000, ex_rs=1, ex_rt=2, ex_wr_reg=3, ex_reg_write=1, ex_alu_src_imm=0.
- 0x3C05ABCD (lui $5) -> ex_alu_op=0010, ex_ext_imm=0xABCD0000, ex_a1_zero=1, ex_wr_reg=5. Then 0x34041234 (ori $4,$0,0x1234) -> ex_ext_imm=0x00001234, ex_wr_reg=4.
- 0x8C26FFFC (lw $6,-4($1)) -> ex_ext_imm=0xFFFFFFFC, ex_mem_read=1, ex_wr_reg=6. Next cycle stall=1 -> ex_valid=0 and all enables 0.
- EX holds addu, then hold=1 and flush=1 for 3 cycles -> outputs unchanged. hold=0 with flush=1 -> bubble.
- id_instr=0xFC000000 -> ex_illegal=1, ex_valid=1, ex_reg_write=0, ex_mem_write=0. id_instr=0x00221FFF (cadd $3) -> ex_alu_op=0100.

Source files
------------

// File: rtl/id_ex_decode_reg.sv
// id_ex_decode_reg
//   Decodes the instruction in ID into the ALU_op encoding and the operand,
//   write-back and memory controls, then registers them into EX.
//   The EX register can be frozen (hold) or loaded with a bubble (stall,
//   flush, or an invalid ID slot).
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-high reset; clears the EX register
//   id_instr       instruction in ID
//   id_pc          PC of id_instr
//   id_valid       id_instr is a real instruction
//   hold           freeze the EX register; overrides stall and flush
//   stall          ID does not advance; EX receives a bubble
//   flush          ID instruction discarded; EX receives a bubble
//   ex_alu_op      ALU_op: 0000 add, 0001 sub, 0010 or, 0100 checked add
//   ex_alu_src_imm ALU A2 takes ex_ext_imm instead of the rt value
//   ex_a1_zero     ALU A1 forced to zero (lui)
//   ex_ext_imm     extended immediate
//   ex_rs, ex_rt   source register numbers for forwarding
//   ex_wr_reg      destination register, 0 when nothing is written
//   ex_reg_write   instruction writes a GPR
//   ex_mem_read    lw
//   ex_mem_write   sw
//   ex_branch      beq
//   ex_illegal     unrecognised instruction
//   ex_valid       EX holds a real instruction
//   ex_pc          PC of the EX instruction
module id_ex_decode_reg #(
  parameter int         PC_W   = 32,
  parameter logic [3:0] NOP_OP = 4'b0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     id_instr,
  input  logic [PC_W-1:0] id_pc,
  input  logic            id_valid,
  input  logic            hold,
  input  logic            stall,
  input  logic            flush,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src_imm,
  output logic            ex_a1_zero,
  output logic [31:0]     ex_ext_imm,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_wr_reg,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_illegal,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_CADD = 4'b0100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_CADD  = 6'b111111;

  function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
    return 32'(v);
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

  function automatic logic [31:0] upper16(input logic [15:0] v);
    return {v, 16'h0000};
  endfunction

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [15:0] f_imm;

  assign op    = id_instr[31:26];
  assign funct = id_instr[5:0];
  assign f_rs  = id_instr[25:21];
  assign f_rt  = id_instr[20:16];
  assign f_rd  = id_instr[15:11];
  assign f_imm = id_instr[15:0];

  // ---- decode stage (p0): combinational decode of id_instr ----
  logic [3:0]  alu_op_p0;
  logic        alu_src_imm_p0;
  logic        a1_zero_p0;
  logic [31:0] ext_imm_p0;
  logic [4:0]  dest_p0;
  logic        writes_p0;
  logic [4:0]  wr_reg_p0;
  logic        reg_write_p0;
  logic        mem_read_p0;
  logic        mem_write_p0;
  logic        branch_p0;
  logic        illegal_p0;

  always_comb begin
    alu_op_p0      = NOP_OP;
    alu_src_imm_p0 = 1'b0;
    a1_zero_p0     = 1'b0;
    ext_imm_p0     = 32'h0;
    dest_p0        = 5'd0;
    writes_p0      = 1'b0;
    mem_read_p0    = 1'b0;
    mem_write_p0   = 1'b0;
    branch_p0      = 1'b0;
    illegal_p0     = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        if (id_instr == 32'h0) begin
          alu_op_p0 = ALU_ADD;
        end else begin
          unique case (funct)
            FN_ADDU: begin alu_op_p0 = ALU_ADD;  dest_p0 = f_rd; writes_p0 = 1'b1; end
            FN_SUBU: begin alu_op_p0 = ALU_SUB;  dest_p0 = f_rd; writes_p0 = 1'b1; end
            FN_CADD: begin alu_op_p0 = ALU_CADD; dest_p0 = f_rd; writes_p0 = 1'b1; end
            default: illegal_p0 = 1'b1;
          endcase
        end
      end
      OP_ORI: begin
        alu_op_p0      = ALU_OR;
        alu_src_imm_p0 = 1'b1;
        ext_imm_p0     = zext16(f_imm);
        dest_p0        = f_rt;
        writes_p0      = 1'b1;
      end
      OP_LUI: begin
        // lui is evaluated as 0 | {imm,16'h0}
        alu_op_p0      = ALU_OR;
        alu_src_imm_p0 = 1'b1;
        a1_zero_p0     = 1'b1;
        ext_imm_p0     = upper16(f_imm);
        dest_p0        = f_rt;
        writes_p0      = 1'b1;
      end
      OP_LW: begin
        alu_op_p0      = ALU_ADD;
        alu_src_imm_p0 = 1'b1;
        ext_imm_p0     = sext16(f_imm);
        dest_p0        = f_rt;
        writes_p0      = 1'b1;
        mem_read_p0    = 1'b1;
      end
      OP_SW: begin
        alu_op_p0      = ALU_ADD;
        alu_src_imm_p0 = 1'b1;
        ext_imm_p0     = sext16(f_imm);
        mem_write_p0   = 1'b1;
      end
      OP_BEQ: begin
        // compare by subtraction of rt; offset carried for the branch target
        alu_op_p0  = ALU_SUB;
        ext_imm_p0 = sext16(f_imm);
        branch_p0  = 1'b1;
      end
      default: illegal_p0 = 1'b1;
    endcase
  end

  // A write to $0 is suppressed so that reg_write always implies wr_reg != 0.
  assign reg_write_p0 = writes_p0 && (dest_p0 != 5'd0);
  assign wr_reg_p0    = reg_write_p0 ? dest_p0 : 5'd0;

  logic bubble;
  assign bubble = flush || stall || !id_valid;

  // ---- EX register (p1 boundary): reset > hold > bubble > load ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_alu_op      <= NOP_OP;
      ex_alu_src_imm <= 1'b0;
      ex_a1_zero     <= 1'b0;
      ex_ext_imm     <= 32'h0;
      ex_rs          <= 5'd0;
      ex_rt          <= 5'd0;
      ex_wr_reg      <= 5'd0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_illegal     <= 1'b0;
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
    end else if (hold) begin
      ex_valid <= ex_valid;
    end else if (bubble) begin
      ex_alu_op      <= NOP_OP;
      ex_alu_src_imm <= 1'b0;
      ex_a1_zero     <= 1'b0;
      ex_ext_imm     <= 32'h0;
      ex_rs          <= 5'd0;
      ex_rt          <= 5'd0;
      ex_wr_reg      <= 5'd0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_illegal     <= 1'b0;
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
    end else begin
      ex_alu_op      <= alu_op_p0;
      ex_alu_src_imm <= alu_src_imm_p0;
      ex_a1_zero     <= a1_zero_p0;
      ex_ext_imm     <= ext_imm_p0;
      ex_rs          <= f_rs;
      ex_rt          <= f_rt;
      ex_wr_reg      <= wr_reg_p0;
      ex_reg_write   <= reg_write_p0;
      ex_mem_read    <= mem_read_p0;
      ex_mem_write   <= mem_write_p0;
      ex_branch      <= branch_p0;
      ex_illegal     <= illegal_p0;
      ex_valid       <= 1'b1;
      ex_pc          <= id_pc;
    end
  end

endmodule

// File: tb/tb_id_ex_decode_reg.sv
module tb_id_ex_decode_reg;

  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     id_instr;
  logic [PC_W-1:0] id_pc;
  logic            id_valid;
  logic            hold;
  logic            stall;
  logic            flush;
  logic [3:0]      ex_alu_op;
  logic            ex_alu_src_imm;
  logic            ex_a1_zero;
  logic [31:0]     ex_ext_imm;
  logic [4:0]      ex_rs;
  logic [4:0]      ex_rt;
  logic [4:0]      ex_wr_reg;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_branch;
  logic            ex_illegal;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;

  int errors = 0;
  int checks = 0;

  id_ex_decode_reg #(.PC_W(PC_W), .NOP_OP(4'b0000)) dut (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_pc(id_pc),
    .id_valid(id_valid), .hold(hold), .stall(stall), .flush(flush),
    .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm),
    .ex_a1_zero(ex_a1_zero), .ex_ext_imm(ex_ext_imm), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_wr_reg(ex_wr_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal), .ex_valid(ex_valid),
    .ex_pc(ex_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present inputs, then advance one edge and sample 1 time unit later.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc);
    id_instr = ins;
    id_pc    = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"},  ex_valid,     0);
    chk({tag, ".alu"},    ex_alu_op,    0);
    chk({tag, ".rw"},     ex_reg_write, 0);
    chk({tag, ".mr"},     ex_mem_read,  0);
    chk({tag, ".mw"},     ex_mem_write, 0);
    chk({tag, ".wr"},     ex_wr_reg,    0);
    chk({tag, ".imm"},    ex_ext_imm,   0);
    chk({tag, ".pc"},     ex_pc,        0);
  endtask

  initial begin
    reset = 1'b1; id_instr = 32'h0; id_pc = '0;
    id_valid = 1'b0; hold = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_bubble("rst");
    chk("rst.illegal", ex_illegal, 0);
    chk("rst.rs",      ex_rs, 0);
    chk("rst.rt",      ex_rt, 0);
    @(negedge clk);
    reset = 1'b0;
    id_valid = 1'b1;

    // addu $3,$1,$2
    step(32'h00221821, 32'h100);
    chk("addu.valid", ex_valid, 1);
    chk("addu.alu",   ex_alu_op, 4'b0000);
    chk("addu.rs",    ex_rs, 1);
    chk("addu.rt",    ex_rt, 2);
    chk("addu.wr",    ex_wr_reg, 3);
    chk("addu.rw",    ex_reg_write, 1);
    chk("addu.src",   ex_alu_src_imm, 0);
    chk("addu.pc",    ex_pc, 32'h100);

    // lui $5,0xABCD
    step(32'h3C05ABCD, 32'h104);
    chk("lui.alu",  ex_alu_op, 4'b0010);
    chk("lui.imm",  ex_ext_imm, 32'hABCD0000);
    chk("lui.a1z",  ex_a1_zero, 1);
    chk("lui.src",  ex_alu_src_imm, 1);
    chk("lui.wr",   ex_wr_reg, 5);
    chk("lui.rw",   ex_reg_write, 1);

    // ori $4,$0,0x1234
    step(32'h34041234, 32'h108);
    chk("ori.alu",  ex_alu_op, 4'b0010);
    chk("ori.imm",  ex_ext_imm, 32'h00001234);
    chk("ori.a1z",  ex_a1_zero, 0);
    chk("ori.wr",   ex_wr_reg, 4);

    // lw $6,-4($1)
    step(32'h8C26FFFC, 32'h10C);
    chk("lw.imm",   ex_ext_imm, 32'hFFFFFFFC);
    chk("lw.mr",    ex_mem_read, 1);
    chk("lw.wr",    ex_wr_reg, 6);
    chk("lw.rs",    ex_rs, 1);

    // load-use stall gives a bubble
    stall = 1'b1;
    step(32'h00221821, 32'h110);
    chk_bubble("stall");
    stall = 1'b0;

    // addu into EX, then hold with flush
    step(32'h00221821, 32'h110);
    chk("addu2.valid", ex_valid, 1);
    hold = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(32'h3C05ABCD, 32'h114);
      chk("hold.valid", ex_valid, 1);
      chk("hold.wr",    ex_wr_reg, 3);
      chk("hold.alu",   ex_alu_op, 4'b0000);
      chk("hold.rw",    ex_reg_write, 1);
      chk("hold.a1z",   ex_a1_zero, 0);
      chk("hold.pc",    ex_pc, 32'h110);
    end
    hold = 1'b0;
    step(32'h3C05ABCD, 32'h114);
    chk_bubble("flush");
    flush = 1'b0;

    // illegal opcode
    step(32'hFC000000, 32'h118);
    chk("ill.illegal", ex_illegal, 1);
    chk("ill.valid",   ex_valid, 1);
    chk("ill.rw",      ex_reg_write, 0);
    chk("ill.mw",      ex_mem_write, 0);
    chk("ill.mr",      ex_mem_read, 0);
    chk("ill.alu",     ex_alu_op, 4'b0000);

    // cadd $3,$1,$2
    step(32'h00221FFF, 32'h11C);
    chk("cadd.alu",     ex_alu_op, 4'b0100);
    chk("cadd.wr",      ex_wr_reg, 3);
    chk("cadd.rw",      ex_reg_write, 1);
    chk("cadd.illegal", ex_illegal, 0);

    // subu $3,$1,$2
    step(32'h00221823, 32'h120);
    chk("subu.alu", ex_alu_op, 4'b0001);
    chk("subu.wr",  ex_wr_reg, 3);

    // addu $0,$1,$2 : write to $0 suppressed
    step(32'h00220021, 32'h124);
    chk("addu0.rw",    ex_reg_write, 0);
    chk("addu0.wr",    ex_wr_reg, 0);
    chk("addu0.valid", ex_valid, 1);

    // sw $2,-16($1)
    step(32'hAC22FFF0, 32'h128);
    chk("sw.mw",  ex_mem_write, 1);
    chk("sw.rw",  ex_reg_write, 0);
    chk("sw.imm", ex_ext_imm, 32'hFFFFFFF0);
    chk("sw.src", ex_alu_src_imm, 1);

    // beq $1,$2,3
    step(32'h10220003, 32'h12C);
    chk("beq.alu", ex_alu_op, 4'b0001);
    chk("beq.br",  ex_branch, 1);
    chk("beq.src", ex_alu_src_imm, 0);
    chk("beq.rw",  ex_reg_write, 0);

    // nop
    step(32'h00000000, 32'h130);
    chk("nop.illegal", ex_illegal, 0);
    chk("nop.rw",      ex_reg_write, 0);
    chk("nop.valid",   ex_valid, 1);
    chk("nop.br",      ex_branch, 0);

    // other sll encodings are not recognised
    step(32'h00021080, 32'h134);
    chk("sll.illegal", ex_illegal, 1);

    // invalid ID slot
    id_valid = 1'b0;
    step(32'h00221821, 32'h138);
    chk_bubble("novalid");
    id_valid = 1'b1;

    // async reset mid-cycle after a load
    step(32'h8C26FFFC, 32'h13C);
    chk("pre.mr", ex_mem_read, 1);
    #2 reset = 1'b1;
    #1;
    chk_bubble("arst");
    #1 reset = 1'b0;
    step(32'h3C05ABCD, 32'h140);
    chk("post.valid", ex_valid, 1);
    chk("post.imm",   ex_ext_imm, 32'hABCD0000);
    chk("post.pc",    ex_pc, 32'h140);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
